// File: rtl/zap_tlb_walker_if.sv
// zap_tlb_walker_if: read-only descriptor fetch bus between the walker and memory.
interface zap_tlb_walker_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          wb_cyc;
  logic          wb_stb;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat;
  logic          wb_ack;
  logic          wb_err;

  // Walker side: issues the fetch, receives descriptor data and completion.
  modport master (
    output wb_cyc,
    output wb_stb,
    output wb_adr,
    input  wb_dat,
    input  wb_ack,
    input  wb_err
  );

  // Memory side: observes the fetch, returns data with ack or flags err.
  modport slave (
    input  wb_cyc,
    input  wb_stb,
    input  wb_adr,
    output wb_dat,
    output wb_ack,
    output wb_err
  );
endinterface

// File: rtl/zap_tlb_walker.sv
// zap_tlb_walker: two-level translation table walker (section / coarse / fine).
// Fetches the L1 descriptor, optionally an L2 descriptor, then issues a single
// one-hot TLB write or a fault pulse with FSR/FAR.
// Build option: define ZAP_TLB_FINE_PAGE_EN to support fine (type 11) L1 tables;
// without it an L1 type 11 descriptor is a translation fault and o_tlb_wen[3]
// is never set.
module zap_tlb_walker (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_walk,
  input  logic [31:0]             i_va,
  input  logic [31:0]             i_baddr,
  input  logic                    i_flush,
  output logic                    o_busy,
  zap_tlb_walker_if.master        wb,
  output logic [3:0]              o_tlb_wen,
  output logic [31:0]             o_tlb_va,
  output logic [31:0]             o_tlb_desc,
  output logic [3:0]              o_tlb_dac_sel,
  output logic                    o_fault,
  output logic [7:0]              o_fsr,
  output logic [31:0]             o_far
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned WEN_W = 4;
  localparam int unsigned DOM_W = 4;
  localparam int unsigned FSR_W = 8;

  localparam logic [3:0] ST_L1_TRANS = 4'h5;
  localparam logic [3:0] ST_L2_TRANS = 4'h7;
  localparam logic [3:0] ST_L1_BUS   = 4'hC;
  localparam logic [3:0] ST_L2_BUS   = 4'hE;

  localparam logic [WEN_W-1:0] WEN_SMALL = 4'b0001;
  localparam logic [WEN_W-1:0] WEN_LARGE = 4'b0010;
  localparam logic [WEN_W-1:0] WEN_SECT  = 4'b0100;
`ifdef ZAP_TLB_FINE_PAGE_EN
  localparam logic [WEN_W-1:0] WEN_FINE  = 4'b1000;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_FETCH,
    S_L2_FETCH,
    S_WRITE,
    S_FAULT,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     va_q, va_d;
  logic [DOM_W-1:0]  dom_q, dom_d;
`ifdef ZAP_TLB_FINE_PAGE_EN
  logic              fine_q, fine_d;
`endif
  logic              cyc_q, cyc_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [WEN_W-1:0]  wen_q, wen_d;
  logic [AW-1:0]     tva_q, tva_d;
  logic [DW-1:0]     tdesc_q, tdesc_d;
  logic [DOM_W-1:0]  dac_q, dac_d;
  logic              fault_q, fault_d;
  logic [FSR_W-1:0]  fsr_q, fsr_d;
  logic [AW-1:0]     far_q, far_d;
  logic              busy_q, busy_d;

  logic              do_write;
  logic [WEN_W-1:0]  wr_wen;
  logic [DW-1:0]     wr_desc;
  logic [DOM_W-1:0]  wr_dom;
  logic              do_fault;
  logic [3:0]        flt_status;
  logic [DOM_W-1:0]  flt_dom;
  logic              bus_done;

  // Low table-base bits are architecturally ignored.
  logic unused_baddr;
  assign unused_baddr = ^i_baddr[13:0];

  assign bus_done = wb.wb_ack | wb.wb_err;

  // State and registered outputs; reset abandons any bus cycle immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      dom_q   <= '0;
`ifdef ZAP_TLB_FINE_PAGE_EN
      fine_q  <= 1'b0;
`endif
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      wen_q   <= '0;
      tva_q   <= '0;
      tdesc_q <= '0;
      dac_q   <= '0;
      fault_q <= 1'b0;
      fsr_q   <= '0;
      far_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      dom_q   <= dom_d;
`ifdef ZAP_TLB_FINE_PAGE_EN
      fine_q  <= fine_d;
`endif
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      wen_q   <= wen_d;
      tva_q   <= tva_d;
      tdesc_q <= tdesc_d;
      dac_q   <= dac_d;
      fault_q <= fault_d;
      fsr_q   <= fsr_d;
      far_q   <= far_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, bus request and TLB-write/fault decode.
  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    dom_d      = dom_q;
`ifdef ZAP_TLB_FINE_PAGE_EN
    fine_d     = fine_q;
`endif
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    do_write   = 1'b0;
    wr_wen     = '0;
    wr_desc    = '0;
    wr_dom     = '0;
    do_fault   = 1'b0;
    flt_status = '0;
    flt_dom    = '0;

    case (state_q)
      S_IDLE: begin
        if (i_walk && !i_flush) begin
          state_d = S_L1_FETCH;
          va_d    = i_va;
          dom_d   = '0;
`ifdef ZAP_TLB_FINE_PAGE_EN
          fine_d  = 1'b0;
`endif
          cyc_d   = 1'b1;
          adr_d   = {i_baddr[31:14], i_va[31:20], 2'b00};
        end
      end

      S_L1_FETCH: begin
        if (i_flush) begin
          if (bus_done) begin
            cyc_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (wb.wb_err) begin
          cyc_d      = 1'b0;
          do_fault   = 1'b1;
          flt_status = ST_L1_BUS;
          flt_dom    = '0;
        end else if (wb.wb_ack) begin
          cyc_d = 1'b0;
          dom_d = wb.wb_dat[8:5];
          case (wb.wb_dat[1:0])
            2'b00: begin
              do_fault   = 1'b1;
              flt_status = ST_L1_TRANS;
              flt_dom    = wb.wb_dat[8:5];
            end
            2'b10: begin
              do_write = 1'b1;
              wr_wen   = WEN_SECT;
              wr_desc  = wb.wb_dat;
              wr_dom   = wb.wb_dat[8:5];
            end
            2'b01: begin
              state_d = S_L2_FETCH;
              cyc_d   = 1'b1;
              adr_d   = {wb.wb_dat[31:10], va_q[19:12], 2'b00};
            end
            default: begin
`ifdef ZAP_TLB_FINE_PAGE_EN
              state_d = S_L2_FETCH;
              fine_d  = 1'b1;
              cyc_d   = 1'b1;
              adr_d   = {wb.wb_dat[31:12], va_q[19:10], 2'b00};
`else
              do_fault   = 1'b1;
              flt_status = ST_L1_TRANS;
              flt_dom    = wb.wb_dat[8:5];
`endif
            end
          endcase
        end
      end

      S_L2_FETCH: begin
        if (i_flush) begin
          if (bus_done) begin
            cyc_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (wb.wb_err) begin
          cyc_d      = 1'b0;
          do_fault   = 1'b1;
          flt_status = ST_L2_BUS;
          flt_dom    = dom_q;
        end else if (wb.wb_ack) begin
          cyc_d   = 1'b0;
          wr_desc = wb.wb_dat;
          wr_dom  = dom_q;
          flt_dom = dom_q;
          case (wb.wb_dat[1:0])
            2'b01: begin
              do_write = 1'b1;
              wr_wen   = WEN_LARGE;
            end
            2'b10: begin
              do_write = 1'b1;
              wr_wen   = WEN_SMALL;
            end
            2'b11: begin
`ifdef ZAP_TLB_FINE_PAGE_EN
              if (fine_q) begin
                do_write = 1'b1;
                wr_wen   = WEN_FINE;
              end else begin
                do_fault   = 1'b1;
                flt_status = ST_L2_TRANS;
              end
`else
              do_fault   = 1'b1;
              flt_status = ST_L2_TRANS;
`endif
            end
            default: begin
              do_fault   = 1'b1;
              flt_status = ST_L2_TRANS;
            end
          endcase
        end
      end

      S_WRITE, S_FAULT: state_d = S_IDLE;

      S_DRAIN: begin
        if (bus_done) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    if (do_write) state_d = S_WRITE;
    if (do_fault) state_d = S_FAULT;
  end

  // Output-register loads for the one-cycle TLB write and fault report.
  always_comb begin
    wen_d   = do_write ? wr_wen : '0;
    tva_d   = do_write ? va_q : tva_q;
    tdesc_d = do_write ? wr_desc : tdesc_q;
    dac_d   = do_write ? wr_dom : dac_q;
    fault_d = do_fault;
    fsr_d   = do_fault ? {flt_dom, flt_status} : fsr_q;
    far_d   = do_fault ? va_q : far_q;
    busy_d  = (state_d != S_IDLE);
  end

  assign wb.wb_cyc     = cyc_q;
  assign wb.wb_stb     = cyc_q;
  assign wb.wb_adr     = adr_q;
  assign o_busy        = busy_q;
  assign o_tlb_va      = tva_q;
  assign o_tlb_desc    = tdesc_q;
  assign o_tlb_dac_sel = dac_q;
  assign o_fsr         = fsr_q;
  assign o_far         = far_q;

  // A flush arriving in the write/fault cycle kills the update in that same cycle.
  assign o_tlb_wen     = wen_q & {WEN_W{~i_flush}};
  assign o_fault       = fault_q & ~i_flush;

endmodule

// File: tb/tb_zap_tlb_walker.sv
// tb_zap_tlb_walker: scoreboard bench for the page table walker.
module tb_zap_tlb_walker;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_walk;
  logic [31:0] i_va;
  logic [31:0] i_baddr;
  logic        i_flush;
  logic        o_busy;
  logic [3:0]  o_tlb_wen;
  logic [31:0] o_tlb_va;
  logic [31:0] o_tlb_desc;
  logic [3:0]  o_tlb_dac_sel;
  logic        o_fault;
  logic [7:0]  o_fsr;
  logic [31:0] o_far;

  zap_tlb_walker_if wb ();

  zap_tlb_walker dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_walk        (i_walk),
    .i_va          (i_va),
    .i_baddr       (i_baddr),
    .i_flush       (i_flush),
    .o_busy        (o_busy),
    .wb            (wb),
    .o_tlb_wen     (o_tlb_wen),
    .o_tlb_va      (o_tlb_va),
    .o_tlb_desc    (o_tlb_desc),
    .o_tlb_dac_sel (o_tlb_dac_sel),
    .o_fault       (o_fault),
    .o_fsr         (o_fsr),
    .o_far         (o_far)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        is_fault;
    logic [3:0]  wen;
    logic [31:0] va;
    logic [31:0] desc;
    logic [3:0]  dac;
    logic [7:0]  fsr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic void push_write(input logic [3:0] wen, input logic [31:0] va,
                                     input logic [31:0] desc, input logic [3:0] dac);
    exp_t e;
    e.is_fault = 1'b0; e.wen = wen; e.va = va; e.desc = desc; e.dac = dac; e.fsr = '0;
    sb_q.push_back(e);
  endfunction

  function automatic void push_fault(input logic [7:0] fsr, input logic [31:0] va);
    exp_t e;
    e.is_fault = 1'b1; e.wen = '0; e.va = va; e.desc = '0; e.dac = '0; e.fsr = fsr;
    sb_q.push_back(e);
  endfunction

  // Every TLB write or fault pulse must match the oldest pending expectation.
  always @(negedge i_clk) begin
    if (i_reset_n && (o_tlb_wen != 4'b0 || o_fault)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'({o_fault, o_tlb_wen}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_fault) begin
          check("fault_pulse", 32'(o_fault), 32'd1);
          check("fsr", 32'(o_fsr), 32'(mon_e.fsr));
          check("far", o_far, mon_e.va);
          check("fault_no_wen", 32'(o_tlb_wen), 32'd0);
        end else begin
          check("tlb_wen", 32'(o_tlb_wen), 32'(mon_e.wen));
          check("tlb_va", o_tlb_va, mon_e.va);
          check("tlb_desc", o_tlb_desc, mon_e.desc);
          check("dac_sel", 32'(o_tlb_dac_sel), 32'(mon_e.dac));
          check("write_no_fault", 32'(o_fault), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_walk(input logic [31:0] va);
    i_va   = va;
    i_walk = 1'b1;
    tick();
    i_walk = 1'b0;
  endtask

  // Wait for a fetch, check its address, hold it lat cycles, then complete it.
  task automatic serve(input string tag, input logic [31:0] exp_adr, input logic [31:0] dat,
                       input logic err, input int lat);
    int n = 0;
    while (!wb.wb_cyc && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_cyc"}, 32'(wb.wb_cyc & wb.wb_stb), 32'd1);
    check({tag, "_adr"}, wb.wb_adr, exp_adr);
    repeat (lat) tick();
    if (lat > 0) check({tag, "_hold"}, wb.wb_adr, exp_adr);
    wb.wb_dat = dat;
    wb.wb_ack = ~err;
    wb.wb_err = err;
    tick();
    wb.wb_ack = 1'b0;
    wb.wb_err = 1'b0;
    wb.wb_dat = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
    tick();
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_walk    = 1'b0;
    i_va      = '0;
    i_baddr   = 32'h0000_4000;
    i_flush   = 1'b0;
    wb.wb_dat = '0;
    wb.wb_ack = 1'b0;
    wb.wb_err = 1'b0;
    repeat (3) tick();

    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cyc", 32'({wb.wb_cyc, wb.wb_stb}), 32'd0);
    check("rst_wen", 32'(o_tlb_wen), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_fsr", 32'(o_fsr), 32'd0);
    check("rst_far", o_far, 32'd0);
    check("rst_tlb_va", o_tlb_va, 32'd0);
    check("rst_tlb_desc", o_tlb_desc, 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Section mapping, written the cycle after L1 ack.
    push_write(4'b0100, 32'h1234_5678, 32'h8000_0C02, 4'h0);
    start_walk(32'h1234_5678);
    serve("sec_l1", 32'h0000_448C, 32'h8000_0C02, 1'b0, 0);
    check("sec_wen_lat", 32'(o_tlb_wen), 32'h4);
    check("sec_cyc_drop", 32'(wb.wb_cyc), 32'd0);
    wait_idle("sec");

    // Coarse table, small page.
    push_write(4'b0001, 32'h0010_3000, 32'h3000_0FFE, 4'h1);
    start_walk(32'h0010_3000);
    serve("cs_l1", 32'h0000_4004, 32'h0020_0021, 1'b0, 1);
    serve("cs_l2", 32'h0020_000C, 32'h3000_0FFE, 1'b0, 2);
    wait_idle("cs");

    // Coarse table, large page.
    push_write(4'b0010, 32'h0010_7000, 32'h1234_5001, 4'h1);
    start_walk(32'h0010_7000);
    serve("cl_l1", 32'h0000_4004, 32'h0020_0021, 1'b0, 0);
    serve("cl_l2", 32'h0020_001C, 32'h1234_5001, 1'b0, 0);
    wait_idle("cl");

    // L1 translation fault carries the L1 domain.
    push_fault(8'hF5, 32'hABC0_0000);
    start_walk(32'hABC0_0000);
    serve("f1_l1", 32'h0000_6AF0, 32'h0000_01E0, 1'b0, 0);
    check("f1_pulse_lat", 32'(o_fault), 32'd1);
    wait_idle("f1");

    // L2 bus error with L1 domain 3.
    push_fault(8'h3E, 32'h0010_5000);
    start_walk(32'h0010_5000);
    serve("e2_l1", 32'h0000_4004, 32'h0020_0061, 1'b0, 0);
    serve("e2_l2", 32'h0020_0014, 32'h0, 1'b1, 1);
    wait_idle("e2");

    // L1 bus error.
    push_fault(8'h0C, 32'h0020_0000);
    start_walk(32'h0020_0000);
    serve("e1_l1", 32'h0000_4008, 32'h0, 1'b1, 2);
    wait_idle("e1");

    // L2 invalid descriptor.
    push_fault(8'hF7, 32'h0010_1000);
    start_walk(32'h0010_1000);
    serve("f2_l1", 32'h0000_4004, 32'h0020_01E1, 1'b0, 0);
    serve("f2_l2", 32'h0020_0004, 32'h0000_0000, 1'b0, 0);
    wait_idle("f2");

    // Fine-page descriptor under a coarse table is a fault.
    push_fault(8'h27, 32'h0010_2000);
    start_walk(32'h0010_2000);
    serve("cf_l1", 32'h0000_4004, 32'h0020_0041, 1'b0, 0);
    serve("cf_l2", 32'h0020_0008, 32'h0000_0FF3, 1'b0, 0);
    wait_idle("cf");

    // Fine table.
`ifdef ZAP_TLB_FINE_PAGE_EN
    push_write(4'b1000, 32'h00AB_CC00, 32'h5555_0003, 4'h1);
    start_walk(32'h00AB_CC00);
    serve("fn_l1", 32'h0000_4028, 32'h0040_0033, 1'b0, 0);
    serve("fn_l2", 32'h0040_0BCC, 32'h5555_0003, 1'b0, 0);
    wait_idle("fn");
`else
    push_fault(8'h15, 32'h00AB_CC00);
    start_walk(32'h00AB_CC00);
    serve("fn_l1", 32'h0000_4028, 32'h0040_0033, 1'b0, 0);
    check("fn_no_l2", 32'(wb.wb_cyc), 32'd0);
    wait_idle("fn");
`endif

    // Flush during L1 fetch: bus held until ack, then idle with no result.
    start_walk(32'h1234_5678);
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("drain_cyc", 32'(wb.wb_cyc), 32'd1);
    check("drain_busy", 32'(o_busy), 32'd1);
    serve("drain", 32'h0000_448C, 32'h8000_0C02, 1'b0, 3);
    check("drain_busy_low", 32'(o_busy), 32'd0);
    check("drain_cyc_low", 32'(wb.wb_cyc), 32'd0);
    tick();

    // Flush together with walk in idle: walk ignored.
    i_va    = 32'h1234_5678;
    i_walk  = 1'b1;
    i_flush = 1'b1;
    tick();
    i_walk  = 1'b0;
    i_flush = 1'b0;
    check("fw_idle_busy", 32'(o_busy), 32'd0);
    check("fw_idle_cyc", 32'(wb.wb_cyc), 32'd0);
    tick();

    // Flush in the write cycle suppresses the TLB write.
    start_walk(32'h1234_5678);
    serve("fwr_l1", 32'h0000_448C, 32'h8000_0C02, 1'b0, 0);
    i_flush = 1'b1;
    #1;
    check("fwr_wen", 32'(o_tlb_wen), 32'd0);
    tick();
    i_flush = 1'b0;
    wait_idle("fwr");

    // Flush in the fault cycle suppresses the fault pulse.
    start_walk(32'hABC0_0000);
    serve("fft_l1", 32'h0000_6AF0, 32'h0000_01E0, 1'b0, 0);
    i_flush = 1'b1;
    #1;
    check("fft_fault", 32'(o_fault), 32'd0);
    tick();
    i_flush = 1'b0;
    wait_idle("fft");

    // Walk held high: ignored while busy, restarts once back in idle.
    push_write(4'b0100, 32'h1234_5678, 32'h8000_0C02, 4'h0);
    push_write(4'b0100, 32'h1234_5678, 32'h8000_0C02, 4'h0);
    i_va   = 32'h1234_5678;
    i_walk = 1'b1;
    tick();
    serve("hold1", 32'h0000_448C, 32'h8000_0C02, 1'b0, 2);
    tick();
    check("hold_idle", 32'(o_busy), 32'd0);
    tick();
    i_walk = 1'b0;
    check("hold_restart", 32'(wb.wb_cyc), 32'd1);
    serve("hold2", 32'h0000_448C, 32'h8000_0C02, 1'b0, 0);
    wait_idle("hold");

    // Reset during the L2 fetch drops the bus immediately.
    start_walk(32'h0010_3000);
    serve("rl2_l1", 32'h0000_4004, 32'h0020_0021, 1'b0, 0);
    check("rl2_pre_cyc", 32'(wb.wb_cyc), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check("rl2_cyc", 32'(wb.wb_cyc), 32'd0);
    check("rl2_busy", 32'(o_busy), 32'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
